// File: rtl/dds_tbl_writer_if.sv
// Host/generator-facing bus of the DDS waveform table writer.
//   slave  : the table writer (dds_tbl_writer)
//   master : the host configuration path plus the DDS phase accumulator
// Signals:
//   tbl_addr  (m->s, DDS_AW) read address from the phase accumulator
//   tbl_data  (s->m, 8)      registered table byte for tbl_addr
//   wr_start  (m->s, 1)      pulse, begin host stream load at address 0
//   wr_valid  (m->s, 1)      host byte valid
//   wr_data   (m->s, 8)      host byte
//   wr_ready  (s->m, 1)      writer accepts host byte
//   gen_start (m->s, 1)      pulse, begin built-in fill
//   gen_shape (m->s, 2)      0 saw, 1 triangle, 2 square, 3 midscale
//   busy      (s->m, 1)      load or fill in progress
//   done      (s->m, 1)      one-cycle pulse after the last entry is written
interface dds_tbl_writer_if #(
    parameter int unsigned DDS_AW = 8
);
    logic [DDS_AW-1:0] tbl_addr;
    logic [7:0]        tbl_data;
    logic              wr_start;
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_ready;
    logic              gen_start;
    logic [1:0]        gen_shape;
    logic              busy;
    logic              done;

    modport master (
        output tbl_addr,
        input  tbl_data,
        output wr_start,
        output wr_valid,
        output wr_data,
        input  wr_ready,
        output gen_start,
        output gen_shape,
        input  busy,
        input  done
    );

    modport slave (
        input  tbl_addr,
        output tbl_data,
        input  wr_start,
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        input  gen_start,
        input  gen_shape,
        output busy,
        output done
    );
endinterface

// File: rtl/dds_tbl_writer.sv
// DDS waveform table writer.
// Owns the 2^DDS_AW x 8 waveform table RAM, serves the phase accumulator's
// read port with one cycle of latency, and fills the table either from a
// host byte stream (valid/ready) or from a built-in saw / triangle / square /
// midscale fill engine.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  dds_tbl_writer_if.slave (read port, host stream, fill control, status)
//   cksum[15:0] modulo-2^16 sum of bytes written since the last start;
//               present only when DDS_TBL_CKSUM_EN is defined
// Optional feature macro: DDS_TBL_CKSUM_EN
module dds_tbl_writer #(
    parameter int unsigned DDS_AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dds_tbl_writer_if.slave       bus
`ifdef DDS_TBL_CKSUM_EN
    ,
    output logic [15:0]           cksum
`endif
);

    localparam int unsigned DEPTH = 1 << DDS_AW;
    localparam int unsigned PW    = DDS_AW + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GEN    = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Pointer carries one extra bit so the exact end compare never wraps.
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [1:0]        shape_q;
    logic [1:0]        shape_d;

    logic              busy_q;
    logic              busy_d;
    logic              ready_q;
    logic              ready_d;
    logic              done_q;
    logic              done_d;

    logic              we;
    logic [7:0]        wdata;
    logic              clr_sum;
    logic [DDS_AW-1:0] waddr;

    logic [7:0]        fill_s;
    logic [7:0]        fill_t;
    logic [7:0]        fill_val;

    logic [7:0]        ram [DEPTH];
    logic [7:0]        tbl_data_q;

    assign waddr = ptr_q[DDS_AW-1:0];

    // Pointer scaled to an 8-bit phase for the fill functions.
    generate
        if (DDS_AW >= 8) begin : g_scale_down
            assign fill_s = ptr_q[DDS_AW-1 -: 8];
        end else begin : g_scale_up
            assign fill_s = {ptr_q[DDS_AW-1:0], {(8 - DDS_AW){1'b0}}};
        end
    endgenerate

    // Fill engine waveform value for the current pointer.
    assign fill_t = {fill_s[6:0], 1'b0};

    always_comb begin
        fill_val = 8'h80;
        case (shape_q)
            2'd0:    fill_val = fill_s;
            2'd1:    fill_val = fill_s[7] ? ~fill_t : fill_t;
            2'd2:    fill_val = fill_s[7] ? 8'h00 : 8'hFF;
            default: fill_val = 8'h80;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; gen_start has priority over wr_start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.gen_start) begin
                    state_d = ST_GEN;
                end else if (bus.wr_start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (bus.wr_valid && (ptr_q == LAST_PTR)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath control for the current state.
    always_comb begin
        we      = 1'b0;
        wdata   = fill_val;
        ptr_d   = ptr_q;
        shape_d = shape_q;
        clr_sum = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.gen_start) begin
                    ptr_d   = '0;
                    shape_d = bus.gen_shape;
                    clr_sum = 1'b1;
                end else if (bus.wr_start) begin
                    ptr_d   = '0;
                    clr_sum = 1'b1;
                end
            end
            ST_STREAM: begin
                // wr_ready is high for the whole state, so valid alone accepts.
                if (bus.wr_valid) begin
                    we     = 1'b1;
                    wdata  = bus.wr_data;
                    ptr_d  = ptr_q + PW'(1);
                    done_d = (ptr_q == LAST_PTR);
                end
            end
            ST_GEN: begin
                we     = 1'b1;
                wdata  = fill_val;
                ptr_d  = ptr_q + PW'(1);
                done_d = (ptr_q == LAST_PTR);
            end
            default: begin
                ptr_d = '0;
            end
        endcase
        // Status flops follow the next state so they line up with state_q.
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_STREAM);
    end

    // Datapath and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            shape_q <= 2'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            shape_q <= shape_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Table RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    // Registered read port; same-address write returns the old byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_data_q <= 8'h80;
        end else begin
            tbl_data_q <= ram[bus.tbl_addr];
        end
    end

`ifdef DDS_TBL_CKSUM_EN
    logic [15:0] cksum_q;

    // Running sum of written bytes, restarted by each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum_q <= 16'h0000;
        end else if (clr_sum) begin
            cksum_q <= 16'h0000;
        end else if (we) begin
            cksum_q <= cksum_q + 16'(wdata);
        end
    end

    assign cksum = cksum_q;
`else
    logic unused_clr;
    assign unused_clr = clr_sum;
`endif

    assign bus.tbl_data = tbl_data_q;
    assign bus.wr_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: doc/dds_tbl_writer.md
Name: dds_tbl_writer

Overview:
- Owns the waveform table RAM for the DDS generator.
- Serves the generator's read port: address in, registered byte out one clock later.
- Fills the table from one of two sources:
  - a host byte stream with a valid/ready handshake;
  - a built-in fill engine for saw, triangle, square and midscale waveforms.
- Sits between the host configuration path and the DDS phase accumulator.

Parameters:
- DDS_AW, 8, table address width; table depth = 2^DDS_AW; legal range 4..12.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tbl_addr  in  DDS_AW  read address from the DDS phase accumulator.
- tbl_data  out  8  registered table byte for tbl_addr.
- wr_start  in  1  pulse: begin host stream load at address 0.
- wr_valid  in  1  host byte valid.
- wr_data  in  8  host byte.
- wr_ready  out  1  block accepts host byte.
- gen_start  in  1  pulse: begin built-in fill.
- gen_shape  in  2  0 saw, 1 triangle, 2 square, 3 midscale; sampled at gen_start.
- busy  out  1  high while a load or fill is in progress.
- done  out  1  one-cycle pulse when the last entry is written.

Behaviour:
- Reset
  - Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high, rst.
  - rst forces: state IDLE, write pointer 0, tbl_data=8'h80, wr_ready=0, busy=0, done=0.
  - RAM contents are not cleared by reset.
- Read port
  - tbl_data <= ram[tbl_addr] every cycle, independent of state: 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old data.
- States: IDLE, STREAM, GEN.
- IDLE
  - gen_start=1 -> GEN; gen_shape latched; pointer=0.
  - Else wr_start=1 -> STREAM; pointer=0.
  - gen_start and wr_start together: GEN wins.
- STREAM
  - wr_ready=1 for the whole state.
  - On wr_valid&&wr_ready: ram[ptr]<=wr_data; ptr++.
  - Write at ptr=2^DDS_AW-1 -> done=1 next cycle, state IDLE, wr_ready falls that same cycle.
  - wr_valid low stalls with no timeout.
- GEN
  - One write per cycle: ram[ptr]<=f(ptr); ptr++.
  - Last write at ptr=2^DDS_AW-1 -> done pulse, state IDLE.
  - Total 2^DDS_AW cycles in GEN.
- busy=1 exactly while state != IDLE.
- Starts arriving while not IDLE are ignored (no queuing). wr_valid in IDLE or GEN is ignored.
- Fill functions, with s = ptr scaled to 8 bits:
  - DDS_AW>=8: s = ptr[DDS_AW-1:DDS_AW-8].
  - DDS_AW<8: s = ptr<<(8-DDS_AW).
  - Saw: f = s.
  - Triangle: t = {s[6:0],1'b0}; f = s[7] ? ~t : t. Gives 0 up to 0xFE, then 0xFF down to 0x01.
  - Square: f = s[7] ? 8'h00 : 8'hFF.
  - Midscale: f = 8'h80.
- Pointer is DDS_AW+1 bits internally; the end condition is an exact compare, so there is no wrap into a second pass.
- rst asserted mid-operation aborts immediately:
  - entries already written keep their values;
  - no done pulse is produced.

Optional Feature:
- Macro: DDS_TBL_CKSUM_EN.
- Defined:
  - Adds output port cksum[15:0].
  - cksum is a modulo-2^16 sum of every byte written to RAM, stream or GEN.
  - Cleared to 0 on rst and on entry to STREAM or GEN.
  - Holds its value after done until the next start.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high mid-GEN at ptr=37 -> busy=0, done never pulses, tbl_data=8'h80 until the first read after release, entries 0..36 hold the saw value, entry 37 holds its prior value.
- GEN saw, DDS_AW=8 -> busy high exactly 256 cycles, done single pulse. Then tbl_addr=8'h40 -> tbl_data=8'h40 one cycle later.
- GEN triangle, DDS_AW=8 -> readback gives addr 0x00=0x00, 0x7F=0xFE, 0x80=0xFF, 0xFF=0x01.
- STREAM, DDS_AW=4, 16 bytes 0xA0..0xAF with wr_valid toggling every other cycle -> wr_ready stays high, done after the 16th accepted byte, entry 5=0xA5; a 17th wr_valid is ignored with wr_ready=0.
- Same-cycle wr_start and gen_start (shape 2) -> GEN executes, wr_ready stays 0, entries 0x00..0x7F=0xFF and 0x80..0xFF=0x00.
- With DDS_TBL_CKSUM_EN, GEN midscale at DDS_AW=8 -> cksum=16'h8000 at done; a following wr_start clears it to 0.
